// File: rtl/mod_mult.sv
// Modular multiplier: (a*b) mod m, or a^2 mod m in square mode, using an
// interleaved MSB-first shift-add with two conditional subtracts per cycle.
module mod_mult #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ready_in,
  input  logic             mode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] result_out,
  output logic             busy_out,
  output logic             valid_out,
  output logic             error_out
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] result_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             valid_q;
  logic             error_q;

  logic [WIDTH:0]   m_ext_s;
  logic [WIDTH:0]   dbl_s;
  logic [WIDTH:0]   red1_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   red2_s;
  logic [WIDTH-1:0] r_d;
  logic             range_err_s;

  // One iteration: R < M keeps every intermediate within WIDTH+1 bits.
  assign m_ext_s     = {1'b0, m_q};
  assign dbl_s       = {r_q, 1'b0};
  assign red1_s      = (dbl_s >= m_ext_s) ? (dbl_s - m_ext_s) : dbl_s;
  assign sum_s       = red1_s + (b_q[idx_q] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign red2_s      = (sum_s >= m_ext_s) ? (sum_s - m_ext_s) : sum_s;
  assign r_d         = red2_s[WIDTH-1:0];
  assign range_err_s = (m_q == {WIDTH{1'b0}}) || (a_q >= m_q) || (b_q >= m_q);

  // Control FSM with captured operands, accumulator and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      m_q      <= {WIDTH{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      idx_q    <= {IW{1'b0}};
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready_in) begin
            a_q     <= a_in;
            b_q     <= mode_in ? a_in : b_in;
            m_q     <= modulus_in;
            r_q     <= {WIDTH{1'b0}};
            idx_q   <= IW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end else begin
            state_q <= IDLE;
          end
        end
        CHECK: begin
          if (range_err_s) begin
            result_q <= {WIDTH{1'b0}};
            error_q  <= 1'b1;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            state_q  <= ITER;
          end
        end
        ITER: begin
          r_q   <= r_d;
          idx_q <= idx_q - 1'b1;
          if (idx_q == {IW{1'b0}}) begin
            result_q <= r_d;
            error_q  <= 1'b0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            state_q  <= ITER;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result_out = result_q;
  assign busy_out   = busy_q;
  assign valid_out  = valid_q;
  assign error_out  = error_q;

endmodule
